// File: rtl/cpcs_tx_reset_seq.sv
// TX-side reset sequencer for CorePCS.
// Waits for TX PLL lock, holds the lane TX reset, releases it, lets the lane
// settle and then reports readiness. A lock timeout is retried a bounded
// number of times before the sequencer parks in a terminal FAIL state.
// Everything runs on EPCS_TxCLK; pll_lock is synchronized internally.
`timescale 1ns/1ps
module cpcs_tx_reset_seq #(
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       EPCS_TxCLK,
  input  logic       aresetn,
  input  logic       pll_lock,
  input  logic       tx_rst_req,
  output logic       EPCS_TxRSTn,
  output logic       tx_ready,
  output logic       seq_fail,
  output logic [2:0] seq_state,
  output logic [2:0] retry_cnt
);

  // One shared timer, wide enough for the longest of the three intervals.
  localparam int unsigned TMAX_A = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned TMAX   = (TMAX_A > HOLD_CYCLES) ? TMAX_A : HOLD_CYCLES;
  localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef logic [TW-1:0] timer_t;

  localparam timer_t     LOCK_LAST   = timer_t'(LOCK_TIMEOUT - 1);
  localparam timer_t     HOLD_LAST   = timer_t'(HOLD_CYCLES - 1);
  localparam timer_t     SETTLE_LAST = timer_t'(SETTLE_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t     state_q, state_d;
  timer_t     timer_q, timer_d;
  logic [2:0] retry_q, retry_d;
  logic [2:0] retry_inc;
  logic       rearm;
  logic       counting;
  logic       rstn_q, rstn_d;
  logic       ready_q, ready_d;
  logic       fail_q, fail_d;

  // Multi-flop synchronizer bringing the asynchronous PLL lock into EPCS_TxCLK.
  always_ff @(posedge EPCS_TxCLK or negedge aresetn) begin
    if (!aresetn) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State, timer, retry count and the registered lane outputs.
  always_ff @(posedge EPCS_TxCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_RESET;
      timer_q <= '0;
      retry_q <= '0;
      rstn_q  <= 1'b0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic; restart request overrides every other transition.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    rearm     = 1'b0;
    retry_inc = retry_q + 3'd1;

    if (tx_rst_req) begin
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET:     state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_HOLD;
          end else if (timer_q == LOCK_LAST) begin
            if (retry_q != RETRY_MAX) retry_d = retry_inc;
            if (retry_inc >= RETRY_MAX) state_d = ST_FAIL;
            else                        rearm   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!lock_s)                    state_d = ST_WAIT_LOCK;
          else if (timer_q == HOLD_LAST)  state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == SETTLE_LAST) begin
            state_d = ST_READY;
            retry_d = '0;
          end
        end
        ST_READY: if (!lock_s) state_d = ST_WAIT_LOCK;
        ST_FAIL:  state_d = ST_FAIL;
        default:  state_d = ST_RESET;
      endcase
    end

    // Timer only runs in the timed states and restarts on any state change or retry.
    counting = (state_q == ST_WAIT_LOCK) || (state_q == ST_HOLD) || (state_q == ST_SETTLE);
    if ((state_d != state_q) || rearm || tx_rst_req || !counting) timer_d = '0;
    else                                                          timer_d = timer_q + timer_t'(1);

    // Outputs decoded from the next state so they change on the same edge as the state.
    rstn_d  = (state_d == ST_SETTLE) || (state_d == ST_READY);
    ready_d = (state_d == ST_READY);
    fail_d  = (state_d == ST_FAIL);
  end

  assign EPCS_TxRSTn = rstn_q;
  assign tx_ready    = ready_q;
  assign seq_fail    = fail_q;
  assign seq_state   = state_q;
  assign retry_cnt   = retry_q;

endmodule
